// File: rtl/timer_pkg.sv
// Shared types for the seconds countdown timer: FSM state encoding and default width.
// Latency: n/a (types only). Backpressure: n/a.
// No logic here; imported by the timer top level.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned TIMER_WIDTH = 4;

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector for level inputs such as buttons or start requests.
// Latency: pulse is combinational in the cycle d is first seen high.
// Backpressure: none; a held level produces exactly one pulse.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown driven by the divider's one_hz_enable strobe; optional pause via COUNTDOWN_TIMER_PAUSE_EN.
// Latency: outputs update on the edge that samples the start or strobe.
// Backpressure: none; a start edge always wins over a coincident strobe.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_timer,
    input  logic [WIDTH-1:0] value,
    input  logic             one_hz_enable,
`ifdef COUNTDOWN_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             divider_restart,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             expired
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             restart_q, restart_d;
    logic             busy_q, busy_d;
    logic             expired_q, expired_d;
    logic             start_edge;
    logic             count_en;

    rise_detect u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (start_timer),
        .pulse   (start_edge)
    );

`ifdef COUNTDOWN_TIMER_PAUSE_EN
    assign count_en = one_hz_enable & ~pause;
`else
    assign count_en = one_hz_enable;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        restart_d   = 1'b0;
        if (start_edge) begin
            // A start from any state reloads; a coincident strobe is dropped.
            remaining_d = value;
            restart_d   = 1'b1;
            state_d     = (value != '0) ? COUNT : DONE;
        end else begin
            case (state_q)
                COUNT: begin
                    if (count_en) begin
                        if (remaining_q > WIDTH'(1)) begin
                            remaining_d = remaining_q - WIDTH'(1);
                        end else begin
                            remaining_d = '0;
                            state_d     = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d    = (state_d == COUNT);
        expired_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            restart_q   <= 1'b0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            restart_q   <= restart_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
        end
    end

    assign divider_restart = restart_q;
    assign busy            = busy_q;
    assign remaining       = remaining_q;
    assign expired         = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: load, decrement, completion, restart, reset and pause.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start_timer = 1'b0;
    logic [W-1:0] value = '0;
    logic         one_hz_enable = 1'b0;
    logic         pause = 1'b0;
    logic         divider_restart;
    logic         busy;
    logic [W-1:0] remaining;
    logic         expired;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start_timer     (start_timer),
        .value           (value),
        .one_hz_enable   (one_hz_enable),
`ifdef COUNTDOWN_TIMER_PAUSE_EN
        .pause           (pause),
`endif
        .divider_restart (divider_restart),
        .busy            (busy),
        .remaining       (remaining),
        .expired         (expired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({divider_restart, busy, expired, remaining} !== {3'b000, 4'd0}) begin
            n_err++;
            $display("FAIL reset_outputs: got r=%b b=%b e=%b rem=%0d want all 0",
                     divider_restart, busy, expired, remaining);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_vec++;
        if ({divider_restart, busy, expired, remaining} !== {3'b000, 4'd0}) begin
            n_err++;
            $display("FAIL idle_after_reset: got r=%b b=%b e=%b rem=%0d want all 0",
                     divider_restart, busy, expired, remaining);
        end
    endtask

    task automatic test_basic_count();
        int restarts;
        int exp_rem;
        restarts = 0;
        start_timer = 1'b1;
        value = 4'd3;
        tick();
        restarts += int'(divider_restart);
        n_vec++;
        if ({divider_restart, busy, expired, remaining} !== {3'b110, 4'd3}) begin
            n_err++;
            $display("FAIL basic_load: got r=%b b=%b e=%b rem=%0d want r=1 b=1 e=0 rem=3",
                     divider_restart, busy, expired, remaining);
        end
        start_timer = 1'b0;
        value = 4'd9;
        exp_rem = 3;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 9; c++) begin
                tick();
                restarts += int'(divider_restart);
            end
            n_vec++;
            if (remaining !== 4'(exp_rem) || expired !== 1'b0) begin
                n_err++;
                $display("FAIL basic_hold: got rem=%0d e=%b want rem=%0d e=0", remaining, expired, exp_rem);
            end
            one_hz_enable = 1'b1;
            tick();
            one_hz_enable = 1'b0;
            restarts += int'(divider_restart);
            exp_rem--;
            n_vec++;
            if (remaining !== 4'(exp_rem)) begin
                n_err++;
                $display("FAIL basic_step: got rem=%0d want %0d", remaining, exp_rem);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || expired !== 1'b1) begin
            n_err++;
            $display("FAIL basic_complete: got b=%b e=%b want b=0 e=1", busy, expired);
        end
        tick();
        n_vec++;
        if (expired !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_expire_width: got b=%b e=%b want b=0 e=0", busy, expired);
        end
        n_vec++;
        if (restarts !== 1) begin
            n_err++;
            $display("FAIL basic_restart_count: got %0d want 1", restarts);
        end
    endtask

    task automatic test_held_start();
        int restarts;
        int expires;
        int exp_cycle;
        restarts = 0;
        expires = 0;
        exp_cycle = -1;
        start_timer = 1'b1;
        value = 4'd2;
        for (int i = 1; i <= 50; i++) begin
            one_hz_enable = (i == 10 || i == 20);
            tick();
            restarts += int'(divider_restart);
            if (expired) begin
                expires++;
                exp_cycle = i;
            end
            n_vec++;
            if (busy && expired) begin
                n_err++;
                $display("FAIL held_busy_and_expired: cycle %0d both high", i);
            end
        end
        one_hz_enable = 1'b0;
        n_vec++;
        if (restarts !== 1 || expires !== 1 || exp_cycle !== 20) begin
            n_err++;
            $display("FAIL held_single_load: got restarts=%0d expires=%0d at=%0d want 1 1 20",
                     restarts, expires, exp_cycle);
        end
        n_vec++;
        if (remaining !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL held_final: got rem=%0d b=%b want 0 0", remaining, busy);
        end
        start_timer = 1'b0;
        tick();
    endtask

    task automatic test_zero_load();
        start_timer = 1'b1;
        value = 4'd0;
        tick();
        n_vec++;
        if ({divider_restart, busy, expired, remaining} !== {3'b101, 4'd0}) begin
            n_err++;
            $display("FAIL zero_load: got r=%b b=%b e=%b rem=%0d want r=1 b=0 e=1 rem=0",
                     divider_restart, busy, expired, remaining);
        end
        start_timer = 1'b0;
        tick();
        n_vec++;
        if ({divider_restart, busy, expired, remaining} !== {3'b000, 4'd0}) begin
            n_err++;
            $display("FAIL zero_after: got r=%b b=%b e=%b rem=%0d want all 0",
                     divider_restart, busy, expired, remaining);
        end
    endtask

    task automatic test_max_value();
        start_timer = 1'b1;
        value = 4'd15;
        tick();
        start_timer = 1'b0;
        n_vec++;
        if (remaining !== 4'd15 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL max_load: got rem=%0d b=%b want 15 1", remaining, busy);
        end
        one_hz_enable = 1'b1;
        for (int k = 14; k >= 0; k--) begin
            tick();
            n_vec++;
            if (remaining !== 4'(k) || expired !== (k == 0)) begin
                n_err++;
                $display("FAIL max_step: got rem=%0d e=%b want rem=%0d e=%b", remaining, expired, k, k == 0);
            end
        end
        // Strobes keep arriving after completion and must not wrap the count.
        tick();
        tick();
        one_hz_enable = 1'b0;
        n_vec++;
        if (remaining !== 4'd0 || busy !== 1'b0 || expired !== 1'b0) begin
            n_err++;
            $display("FAIL max_no_wrap: got rem=%0d b=%b e=%b want 0 0 0", remaining, busy, expired);
        end
    endtask

    task automatic test_back_to_back();
        start_timer = 1'b1;
        value = 4'd5;
        tick();
        start_timer = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            one_hz_enable = 1'b1;
            tick();
            one_hz_enable = 1'b0;
        end
        n_vec++;
        if (remaining !== 4'd3) begin
            n_err++;
            $display("FAIL b2b_pre: got rem=%0d want 3", remaining);
        end
        start_timer = 1'b1;
        value = 4'd4;
        one_hz_enable = 1'b1;
        tick();
        start_timer = 1'b0;
        one_hz_enable = 1'b0;
        n_vec++;
        if (remaining !== 4'd4 || divider_restart !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_reload: got rem=%0d r=%b b=%b want rem=4 r=1 b=1",
                     remaining, divider_restart, busy);
        end
        tick();
        n_vec++;
        if (remaining !== 4'd4 || divider_restart !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_hold: got rem=%0d r=%b want rem=4 r=0", remaining, divider_restart);
        end
    endtask

    task automatic test_async_reset();
        int expires;
        expires = 0;
        for (int k = 0; k < 2; k++) begin
            one_hz_enable = 1'b1;
            tick();
            one_hz_enable = 1'b0;
            tick();
        end
        n_vec++;
        if (remaining !== 4'd2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: got rem=%0d b=%b want 2 1", remaining, busy);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({divider_restart, busy, expired, remaining} !== {3'b000, 4'd0}) begin
            n_err++;
            $display("FAIL areset_immediate: got r=%b b=%b e=%b rem=%0d want all 0",
                     divider_restart, busy, expired, remaining);
        end
        tick();
        reset_n = 1'b1;
        one_hz_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expires += int'(expired);
        end
        one_hz_enable = 1'b0;
        n_vec++;
        if (expires !== 0 || remaining !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL areset_after: got expires=%0d rem=%0d b=%b want 0 0 0", expires, remaining, busy);
        end
    endtask

`ifdef COUNTDOWN_TIMER_PAUSE_EN
    task automatic test_pause();
        start_timer = 1'b1;
        value = 4'd3;
        tick();
        start_timer = 1'b0;
        pause = 1'b1;
        for (int k = 0; k < 2; k++) begin
            one_hz_enable = 1'b1;
            tick();
            one_hz_enable = 1'b0;
            tick();
        end
        n_vec++;
        if (remaining !== 4'd3 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pause_hold: got rem=%0d b=%b want 3 1", remaining, busy);
        end
        pause = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            one_hz_enable = 1'b1;
            tick();
            one_hz_enable = 1'b0;
            n_vec++;
            if (remaining !== 4'(k) || expired !== (k == 0)) begin
                n_err++;
                $display("FAIL pause_resume: got rem=%0d e=%b want rem=%0d e=%b", remaining, expired, k, k == 0);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_count();
        test_held_start();
        test_zero_load();
        test_max_value();
        test_back_to_back();
        test_async_reset();
`ifdef COUNTDOWN_TIMER_PAUSE_EN
        test_pause();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
